video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 203 ++++++++++++++++++++
 tb/tb_video_timing_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: pixel requests lead the display outputs by
// REQ_LEAD+1 cycles so an external source can return RGB_In in time.
module video_timing_gen #(
    parameter int CNT_W        = 12,
    parameter int REQ_LEAD     = 2,
    parameter int DEF_H_ACTIVE = 1280,
    parameter int DEF_H_FP     = 110,
    parameter int DEF_H_SYNC   = 40,
    parameter int DEF_H_BP     = 220,
    parameter int DEF_V_ACTIVE = 720,
    parameter int DEF_V_FP     = 5,
    parameter int DEF_V_SYNC   = 5,
    parameter int DEF_V_BP     = 20
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             enable,
    input  logic             cfg_wr,
    input  logic [3:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_wdata,
    input  logic             cfg_commit,
    output logic             cfg_pending,
    output logic             cfg_err,
    output logic             pix_req,
    output logic [CNT_W-1:0] req_x,
    output logic [CNT_W-1:0] req_y,
    output logic             sof,
    input  logic [23:0]      RGB_In,
    output logic [23:0]      RGB_Data,
    output logic             RGB_HSync,
    output logic             RGB_VSync,
    output logic             RGB_VDE,
    output logic [CNT_W-1:0] Set_X,
    output logic [CNT_W-1:0] Set_Y
);
    localparam int SUM_W = CNT_W + 2;
    localparam logic [SUM_W-1:0] SUM_MAX = {2'b00, {CNT_W{1'b1}}};

    function automatic logic [CNT_W-1:0] def_val(input logic [2:0] idx);
        case (idx)
            3'd0:    def_val = CNT_W'(DEF_H_ACTIVE);
            3'd1:    def_val = CNT_W'(DEF_H_FP);
            3'd2:    def_val = CNT_W'(DEF_H_SYNC);
            3'd3:    def_val = CNT_W'(DEF_H_BP);
            3'd4:    def_val = CNT_W'(DEF_V_ACTIVE);
            3'd5:    def_val = CNT_W'(DEF_V_FP);
            3'd6:    def_val = CNT_W'(DEF_V_SYNC);
            default: def_val = CNT_W'(DEF_V_BP);
        endcase
    endfunction

    function automatic logic [SUM_W-1:0] sum3(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b,
                                              input logic [CNT_W-1:0] c);
        sum3 = SUM_W'(a) + SUM_W'(b) + SUM_W'(c);
    endfunction

    // Field order: H_ACTIVE, H_FP, H_SYNC, H_BP, V_ACTIVE, V_FP, V_SYNC, V_BP
    logic [CNT_W-1:0] stg [8];
    logic [CNT_W-1:0] act_f [8];
    logic [1:0]       stg_pol, act_pol;
    logic [CNT_W-1:0] h, v;

    logic [SUM_W-1:0] stg_h_tot, stg_v_tot;
    logic             stg_ok;
    logic [SUM_W-1:0] h_ext, v_ext, h_blank, v_blank, h_last, v_last;
    logic             h_end, v_end, in_act, in_hs, in_vs;
    logic [CNT_W-1:0] x_next, y_next;

    logic                s1_hs, s1_vs;
    logic [REQ_LEAD-1:0] p_act, p_hs, p_vs;
    logic [CNT_W-1:0]    p_x [REQ_LEAD];
    logic [CNT_W-1:0]    p_y [REQ_LEAD];

    // Staged-set sanity check evaluated at commit time.
    always_comb begin
        stg_h_tot = sum3(stg[1], stg[2], stg[3]) + SUM_W'(stg[0]);
        stg_v_tot = sum3(stg[5], stg[6], stg[7]) + SUM_W'(stg[4]);
        stg_ok    = (stg[0] != '0) && (stg[2] != '0) && (stg[4] != '0) && (stg[6] != '0) &&
                    (stg_h_tot <= SUM_MAX) && (stg_v_tot <= SUM_MAX);
    end

    // Raster decode of the current counter state against the active set.
    always_comb begin
        h_ext   = SUM_W'(h);
        v_ext   = SUM_W'(v);
        h_blank = sum3(act_f[1], act_f[2], act_f[3]);
        v_blank = sum3(act_f[5], act_f[6], act_f[7]);
        h_last  = h_blank + SUM_W'(act_f[0]) - SUM_W'(1);
        v_last  = v_blank + SUM_W'(act_f[4]) - SUM_W'(1);
        h_end   = (h_ext == h_last);
        v_end   = (v_ext == v_last);
        in_act  = enable && (h_ext >= h_blank) && (v_ext >= v_blank);
        in_hs   = enable && (h_ext >= SUM_W'(act_f[1])) &&
                  (h_ext < SUM_W'(act_f[1]) + SUM_W'(act_f[2]));
        in_vs   = enable && (v_ext >= SUM_W'(act_f[5])) &&
                  (v_ext < SUM_W'(act_f[5]) + SUM_W'(act_f[6]));
        x_next  = in_act ? CNT_W'(h_ext - h_blank) : '0;
        y_next  = in_act ? CNT_W'(v_ext - v_blank) : '0;
    end

    // Raster counters, parked at the origin while disabled.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            h <= '0;
            v <= '0;
        end else if (!enable) begin
            h <= '0;
            v <= '0;
        end else if (h_end) begin
            h <= '0;
            v <= v_end ? '0 : v + CNT_W'(1);
        end else begin
            h <= h + CNT_W'(1);
        end
    end

    // Staging registers, commit handshake and frame-boundary swap into the active set.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < 8; i++) begin
                stg[i]   <= def_val(3'(i));
                act_f[i] <= def_val(3'(i));
            end
            stg_pol     <= 2'b11;
            act_pol     <= 2'b11;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            cfg_err <= 1'b0;
            if (cfg_wr && !cfg_pending) begin
                if (cfg_addr < 4'd8) begin
                    stg[cfg_addr[2:0]] <= cfg_wdata;
                end else if (cfg_addr == 4'd8) begin
                    stg_pol <= cfg_wdata[1:0];
                end
            end
            if (cfg_pending) begin
                // Swap only where the counters restart at the origin next cycle.
                if (!enable || (h_end && v_end)) begin
                    act_f       <= stg;
                    act_pol     <= stg_pol;
                    cfg_pending <= 1'b0;
                end
            end else if (cfg_commit) begin
                if (stg_ok) begin
                    cfg_pending <= 1'b1;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

    // Request stage, REQ_LEAD-deep delay line, then the display output registers.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            pix_req   <= 1'b0;
            req_x     <= '0;
            req_y     <= '0;
            sof       <= 1'b0;
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            p_act     <= '0;
            p_hs      <= '0;
            p_vs      <= '0;
            for (int i = 0; i < REQ_LEAD; i++) begin
                p_x[i] <= '0;
                p_y[i] <= '0;
            end
            RGB_VDE   <= 1'b0;
            RGB_HSync <= 1'b0;
            RGB_VSync <= 1'b0;
            Set_X     <= '0;
            Set_Y     <= '0;
            RGB_Data  <= 24'd0;
        end else begin
            pix_req  <= in_act;
            req_x    <= x_next;
            req_y    <= y_next;
            sof      <= enable && (h == '0) && (v == '0);
            s1_hs    <= in_hs;
            s1_vs    <= in_vs;
            p_act[0] <= pix_req;
            p_hs[0]  <= s1_hs;
            p_vs[0]  <= s1_vs;
            p_x[0]   <= req_x;
            p_y[0]   <= req_y;
            for (int i = 1; i < REQ_LEAD; i++) begin
                p_act[i] <= p_act[i-1];
                p_hs[i]  <= p_hs[i-1];
                p_vs[i]  <= p_vs[i-1];
                p_x[i]   <= p_x[i-1];
                p_y[i]   <= p_y[i-1];
            end
            RGB_VDE   <= p_act[REQ_LEAD-1];
            RGB_HSync <= p_hs[REQ_LEAD-1] ^ ~act_pol[0];
            RGB_VSync <= p_vs[REQ_LEAD-1] ^ ~act_pol[1];
            Set_X     <= p_x[REQ_LEAD-1];
            Set_Y     <= p_y[REQ_LEAD-1];
            RGB_Data  <= p_act[REQ_LEAD-1] ? RGB_In : 24'd0;
        end
    end
endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: small 8x6 raster, live reconfiguration,
// rejected commits, polarity inversion, enable drop and asynchronous reset.
module tb_video_timing_gen;
    localparam int CNT_W = 12;

    logic             clk = 1'b0;
    logic             rst, enable, cfg_wr, cfg_commit;
    logic [3:0]       cfg_addr;
    logic [CNT_W-1:0] cfg_wdata;
    logic [23:0]      rgb_in;
    logic             cfg_pending, cfg_err, pix_req, sof, rgb_hsync, rgb_vsync, rgb_vde;
    logic [CNT_W-1:0] req_x, req_y, set_x, set_y;
    logic [23:0]      rgb_data;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int c0, hl_switch, s_end;
    bit inv_pol;

    typedef struct packed {
        logic act, hs, vs, sf;
        logic [11:0] x, y;
    } st_t;

    always #5 clk = ~clk;

    video_timing_gen #(.CNT_W(CNT_W), .REQ_LEAD(2)) dut (
        .clk(clk), .Rst(rst), .enable(enable), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_pending(cfg_pending),
        .cfg_err(cfg_err), .pix_req(pix_req), .req_x(req_x), .req_y(req_y), .sof(sof),
        .RGB_In(rgb_in), .RGB_Data(rgb_data), .RGB_HSync(rgb_hsync), .RGB_VSync(rgb_vsync),
        .RGB_VDE(rgb_vde), .Set_X(set_x), .Set_Y(set_y)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Advance to the next falling edge; RGB_In carries the running cycle number.
    task automatic tick();
        @(negedge clk);
        cyc++;
        rgb_in = 24'(cyc);
    endtask

    task automatic cfg_set(input logic [3:0] addr, input logic [11:0] data);
        cfg_wr    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
    endtask

    task automatic cfg_write(input logic [3:0] addr, input logic [11:0] data);
        cfg_set(addr, data);
        tick();
        cfg_wr = 1'b0;
    endtask

    // Reference raster: H 4/1/2/1 (8-cycle lines, 10 from hl_switch on), V 3/1/1/1.
    function automatic st_t model(input int s);
        st_t r;
        int hl, q, hh, vv;
        r = '0;
        if (s < 0 || s >= s_end) return r;
        if (s >= hl_switch) begin
            hl = 10;
            q  = s - hl_switch;
        end else begin
            hl = 8;
            q  = s;
        end
        hh = q % hl;
        vv = (q / hl) % 6;
        r.act = (hh >= 4) && (vv >= 3);
        r.hs  = (hh == 1) || (hh == 2);
        r.vs  = (vv == 1);
        r.sf  = (hh == 0) && (vv == 0);
        if (r.act) begin
            r.x = 12'(hh - 4);
            r.y = 12'(vv - 3);
        end
        return r;
    endfunction

    task automatic check_cycle(input int k);
        st_t a, d;
        logic [23:0] dexp;
        a = model(k - 1);
        d = model(k - 4);
        dexp = d.act ? 24'(c0 + k - 1) : 24'd0;
        chk("sof", 32'(sof), 32'(a.sf));
        chk("pix_req", 32'(pix_req), 32'(a.act));
        chk("req_x", 32'(req_x), 32'(a.x));
        chk("req_y", 32'(req_y), 32'(a.y));
        chk("vde", 32'(rgb_vde), 32'(d.act));
        chk("hsync", 32'(rgb_hsync), 32'(d.hs ^ inv_pol));
        chk("vsync", 32'(rgb_vsync), 32'(d.vs ^ inv_pol));
        chk("set_x", 32'(set_x), 32'(d.x));
        chk("set_y", 32'(set_y), 32'(d.y));
        chk("rgb_data", 32'(rgb_data), 32'(dexp));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pending"}, 32'(cfg_pending), 32'd0);
        chk({tag, "_err"}, 32'(cfg_err), 32'd0);
        chk({tag, "_pix_req"}, 32'(pix_req), 32'd0);
        chk({tag, "_req_x"}, 32'(req_x), 32'd0);
        chk({tag, "_req_y"}, 32'(req_y), 32'd0);
        chk({tag, "_sof"}, 32'(sof), 32'd0);
        chk({tag, "_data"}, 32'(rgb_data), 32'd0);
        chk({tag, "_hsync"}, 32'(rgb_hsync), 32'd0);
        chk({tag, "_vsync"}, 32'(rgb_vsync), 32'd0);
        chk({tag, "_vde"}, 32'(rgb_vde), 32'd0);
        chk({tag, "_set_x"}, 32'(set_x), 32'd0);
        chk({tag, "_set_y"}, 32'(set_y), 32'd0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; cfg_wr = 1'b0; cfg_commit = 1'b0;
        cfg_addr = 4'd0; cfg_wdata = 12'd0; rgb_in = 24'd0;
        hl_switch = 1000000; s_end = 1000000; inv_pol = 1'b0; c0 = 0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Small raster, committed while disabled: applies on the following cycle.
        cfg_write(4'd0, 12'd4); cfg_write(4'd1, 12'd1); cfg_write(4'd2, 12'd2); cfg_write(4'd3, 12'd1);
        cfg_write(4'd4, 12'd3); cfg_write(4'd5, 12'd1); cfg_write(4'd6, 12'd1); cfg_write(4'd7, 12'd1);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("commit_pending", 32'(cfg_pending), 32'd1);
        chk("commit_err", 32'(cfg_err), 32'd0);
        tick();
        chk("idle_swap_pending", 32'(cfg_pending), 32'd0);
        tick(); tick(); tick();

        // Run 1: live H_ACTIVE change, ignored write, two rejected commits, enable drop.
        c0 = cyc; enable = 1'b1; hl_switch = 144; s_end = 280; inv_pol = 1'b0;
        for (int k = 1; k <= 292; k++) begin
            cfg_wr = 1'b0;
            cfg_commit = 1'b0;
            case (k)
                110:     cfg_set(4'd0, 12'd6);
                111:     cfg_commit = 1'b1;
                115:     cfg_set(4'd0, 12'd2);
                220:     cfg_set(4'd6, 12'd0);
                221:     cfg_commit = 1'b1;
                223:     cfg_set(4'd6, 12'd1);
                224:     cfg_set(4'd0, 12'd4092);
                225:     cfg_commit = 1'b1;
                227:     cfg_set(4'd0, 12'd6);
                281:     enable = 1'b0;
                default: ;
            endcase
            tick();
            check_cycle(k);
            chk("run1_pending", 32'(cfg_pending), 32'((k >= 111) && (k <= 143)));
            chk("run1_err", 32'(cfg_err), 32'((k == 221) || (k == 225)));
        end
        cfg_wr = 1'b0;
        cfg_commit = 1'b0;

        // Back to 8-cycle lines with both sync polarities active-low.
        cfg_write(4'd0, 12'd4);
        cfg_write(4'd8, 12'd0);
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        chk("pol_pending", 32'(cfg_pending), 32'd1);
        tick();
        chk("pol_swap_pending", 32'(cfg_pending), 32'd0);
        tick(); tick(); tick();

        c0 = cyc; enable = 1'b1; hl_switch = 1000000; s_end = 1000000; inv_pol = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            check_cycle(k);
            chk("run2_pending", 32'(cfg_pending), 32'd0);
        end

        // Reset mid-line, away from any clock edge.
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        tick();
        chk_all_zero("held_rst");
        rst = 1'b0;
        c0 = cyc;

        // Default 1650x750 raster restarts at the origin.
        for (int k = 1; k <= 8260; k++) begin
            tick();
            if (k == 1)    chk("def_sof_first", 32'(sof), 32'd1);
            if (k == 2)    chk("def_sof_second", 32'(sof), 32'd0);
            if (k == 113)  chk("def_hs_before", 32'(rgb_hsync), 32'd0);
            if (k == 114)  chk("def_hs_rise", 32'(rgb_hsync), 32'd1);
            if (k == 153)  chk("def_hs_last", 32'(rgb_hsync), 32'd1);
            if (k == 154)  chk("def_hs_after", 32'(rgb_hsync), 32'd0);
            if (k == 1651) chk("def_sof_line1", 32'(sof), 32'd0);
            if (k == 8253) chk("def_vs_before", 32'(rgb_vsync), 32'd0);
            if (k == 8254) chk("def_vs_rise", 32'(rgb_vsync), 32'd1);
            if (k == 8254) chk("def_no_pix_req", 32'(pix_req), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
